instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit register-file datapath. It addresses the 16-word instruction ROM through `mar` and drives register-file read and write selects. It latches operands into `a` and `b`, computes `c` in an internal ALU, and writes the result back through `out`. The block is the control core that sits between the instruction ROM and the register file.

## Interface
- `DATA_W`, default 8: datapath width.
- `ADDR_W`, default 4: PC/`mar` width and register-select width.
- `RESET_PC`, default 0: PC value loaded on reset.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr`  in  16  ROM word at `mar`, combinational, valid in the same cycle. Fields: op[15:12], dst[11:8], srcA[7:4], srcB[3:0]; imm8 = [7:0].
- `rd_data`  in  DATA_W  register-file read data for `rd_sel`, combinational.
- `mar`  out  ADDR_W  instruction address (= PC).
- `rd_sel`  out  ADDR_W  register-file read select.
- `wr_sel`  out  ADDR_W  register-file write select.
- `wr_en`  out  1  register-file write strobe.
- `out`  out  DATA_W  write-back data.
- `a`, `b`, `c`  out  DATA_W  operand A latch, operand B latch, ALU result.
- `zero`  out  1  flag: last ALU result was 0.
- `halted`  out  1  high in the HALT state.

## Operation
- States:
  - FETCH: IR <= `instr`; PC <= PC+1, wrapping 15->0.
  - DECODE:
    - ALU ops 1-6 go to RD_A.
    - LDI (7) goes to EXEC.
    - JMP (8): PC <= instr[3:0], then FETCH.
    - JZ (9): if `zero`, PC <= instr[3:0]; then FETCH.
    - HALT (F) goes to HALT.
    - NOP (0) and undefined opcodes go to FETCH.
  - RD_A: `rd_sel` = srcA; `a` <= `rd_data`.
  - RD_B: `rd_sel` = srcB; `b` <= `rd_data`.
  - EXEC: `c` <= ALU(op, a, b), or `c` <= imm8 for LDI. `zero` is updated for ops 1-6 only.
  - WB: `wr_sel` = dst, `wr_en` = 1, `out` = `c`; then FETCH.
  - HALT: absorbing until reset. `mar` frozen, `wr_en` = 0.
- ALU opcodes: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV (`c` = `a`).
- Arithmetic is modulo 2^DATA_W. Carry and borrow are discarded.
- `rd_sel`, `wr_sel`, `a`, `b`, `c` and `out` hold their last value outside the states that update them.
- `wr_en` is high only in WB.

## Timing
- All outputs are registered or decoded from registered state.
- On reset assertion, immediately (asynchronous):
  - state = FETCH, PC = RESET_PC.
  - `rd_sel`, `wr_sel`, `a`, `b`, `c`, `out` = 0.
  - `wr_en`, `zero`, `halted` = 0.
- Reset asserted mid-instruction, including during WB, aborts it. `wr_en` drops asynchronously and no write completes.
- Cycles per instruction:
  - ALU op: 6.
  - LDI: 4.
  - NOP, JMP, JZ: 2.
- Jump target is visible on `mar` in the cycle after DECODE.
- JZ samples the `zero` value held at DECODE.

## Configuration
- `SEQ_STEP_EN` defined: adds input `step` (1 bit). The sequencer stays in FETCH, not latching `instr` and not advancing PC, until `step` is sampled high. Each high sample executes exactly one instruction. Holding `step` high runs continuously.
- `SEQ_STEP_EN` undefined: no `step` port. FETCH always advances in one cycle.

## Structure
- Package `seq_pkg` holds:
  - opcode localparams (OP_NOP…OP_HALT);
  - state encoding typedef `seq_state_t`;
  - instruction field bit positions.
- Sub-module `seq_alu`: combinational, inputs (op, a, b), outputs (result, is_zero). The FSM, PC and latches stay in `instr_sequencer`.

## Test plan
The bench models a 16x8 register file (all zero) and a ROM.
- ALU write-back: ROM = LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> third WB has `wr_sel`=3, `out`=8, `wr_en` for 1 cycle. Total 14 cycles from reset release.
- Wrap-around subtract: SUB r4,r2,r1 (3-5) -> `c`=254, `zero`=0.
- Zero flag and branch: SUB r5,r1,r1 then JZ 0 -> `zero`=1, `mar`=0 after JZ's DECODE. With a nonzero result, `mar` continues sequentially.
- PC wrap: ROM all NOP -> `mar` counts 0..15 then 0, 2 cycles per step.
- HALT: HALT at address 4 -> `halted`=1, `mar`=5 frozen for 20 cycles. Reset then returns `mar`=0, `halted`=0.
- Reset abort: assert reset in the WB cycle of ADD -> `wr_en`=0 in the same cycle and all outputs 0. With `SEQ_STEP_EN` and `step` held low, `mar` stays 0 and no writes occur.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM state
// encoding and instruction-word field positions.
package seq_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_AND  = 4'h3;
    localparam logic [OP_W-1:0] OP_OR   = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h6;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OP_W-1:0] OP_JZ   = 4'h9;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int DST_MSB  = 11;
    localparam int DST_LSB  = 8;
    localparam int SRCA_MSB = 7;
    localparam int SRCA_LSB = 4;
    localparam int SRCB_MSB = 3;
    localparam int SRCB_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WB,
        S_HALT
    } seq_state_t;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND/OR/XOR/MOV, modulo 2^DATA_W,
// with a zero indication on the result.
module seq_alu
    import seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              is_zero
);

    // NOTE: result gets a default before the case so no latch is inferred
    // for opcodes the ALU does not implement.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = a;
            default: result = '0;
        endcase
    end

    assign is_zero = (result == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control core between the instruction ROM and register file.
// Optional single-step gating of FETCH via macro SEQ_STEP_EN (adds input `step`).
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
`ifdef SEQ_STEP_EN
    input  logic               step,
`endif
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [ADDR_W-1:0]  mar,
    output logic [ADDR_W-1:0]  rd_sel,
    output logic [ADDR_W-1:0]  wr_sel,
    output logic               wr_en,
    output logic [DATA_W-1:0]  out,
    output logic [DATA_W-1:0]  a,
    output logic [DATA_W-1:0]  b,
    output logic [DATA_W-1:0]  c,
    output logic               zero,
    output logic               halted
);

    seq_state_t         state, state_next;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic               fetch_go;

    logic [OP_W-1:0]    ir_op;
    logic [ADDR_W-1:0]  ir_dst, ir_src_a, ir_src_b, ir_target;
    logic [DATA_W-1:0]  ir_imm;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero;

`ifdef SEQ_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    assign ir_op     = ir[OP_MSB:OP_LSB];
    assign ir_dst    = ADDR_W'(ir[DST_MSB:DST_LSB]);
    assign ir_src_a  = ADDR_W'(ir[SRCA_MSB:SRCA_LSB]);
    assign ir_src_b  = ADDR_W'(ir[SRCB_MSB:SRCB_LSB]);
    assign ir_target = ADDR_W'(ir[SRCB_MSB:SRCB_LSB]);
    assign ir_imm    = DATA_W'(ir[IMM_MSB:IMM_LSB]);

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (ir_op),
        .a       (a),
        .b       (b),
        .result  (alu_result),
        .is_zero (alu_zero)
    );

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (fetch_go) state_next = S_DECODE;
            S_DECODE: begin
                if (is_alu_op(ir_op))      state_next = S_RD_A;
                else if (ir_op == OP_LDI)  state_next = S_EXEC;
                else if (ir_op == OP_HALT) state_next = S_HALT;
                else                       state_next = S_FETCH;
            end
            S_RD_A:   state_next = S_RD_B;
            S_RD_B:   state_next = S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Selects and out are loaded one state early so they are stable
    // throughout the state that uses them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            rd_sel <= '0;
            wr_sel <= '0;
            a      <= '0;
            b      <= '0;
            c      <= '0;
            out    <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_go) begin
                        ir <= instr;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    if (ir_op == OP_JMP || (ir_op == OP_JZ && zero)) pc <= ir_target;
                    if (is_alu_op(ir_op)) rd_sel <= ir_src_a;
                end
                S_RD_A: begin
                    a      <= rd_data;
                    rd_sel <= ir_src_b;
                end
                S_RD_B: b <= rd_data;
                S_EXEC: begin
                    wr_sel <= ir_dst;
                    if (ir_op == OP_LDI) begin
                        c   <= ir_imm;
                        out <= ir_imm;
                    end else begin
                        c    <= alu_result;
                        out  <= alu_result;
                        zero <= alu_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mar    = pc;
    assign wr_en  = (state == S_WB);
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer with a modelled 16x8 register file and ROM.
// Honours SEQ_STEP_EN when defined for the build.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [7:0]  rd_data;
    logic [3:0]  mar, rd_sel, wr_sel;
    logic        wr_en, zero, halted;
    logic [7:0]  out, a, b, c;
`ifdef SEQ_STEP_EN
    logic        step;
`endif

    logic [15:0] rom [16];
    logic [7:0]  rf  [16];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk     (clk),
        .reset   (reset),
`ifdef SEQ_STEP_EN
        .step    (step),
`endif
        .instr   (instr),
        .rd_data (rd_data),
        .mar     (mar),
        .rd_sel  (rd_sel),
        .wr_sel  (wr_sel),
        .wr_en   (wr_en),
        .out     (out),
        .a       (a),
        .b       (b),
        .c       (c),
        .zero    (zero),
        .halted  (halted)
    );

    assign instr   = rom[mar];
    assign rd_data = rf[rd_sel];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (wr_en) begin
            rf[wr_sel] <= out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    // Reset for two edges, release 1 ns after a rising edge; the next negedge is cycle 1.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_halt_timeout"}, halted, 1);
    endtask

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] exp_c;
        logic       exp_z;
    } alu_vec_t;

    alu_vec_t vecs [10];

    initial begin
        int         wr_cycles;
        int         last_wr;
        logic [3:0] wsel_at;
        logic [7:0] out_at;
        logic       mar_stuck;

        vecs[0] = '{"add",      4'h1, 8'd5,   8'd3,   8'd8,   1'b0};
        vecs[1] = '{"sub_wrap", 4'h2, 8'd3,   8'd5,   8'd254, 1'b0};
        vecs[2] = '{"sub_zero", 4'h2, 8'd7,   8'd7,   8'd0,   1'b1};
        vecs[3] = '{"add_wrap", 4'h1, 8'd200, 8'd56,  8'd0,   1'b1};
        vecs[4] = '{"and",      4'h3, 8'hF0,  8'h3C,  8'h30,  1'b0};
        vecs[5] = '{"or",       4'h4, 8'hF0,  8'h0F,  8'hFF,  1'b0};
        vecs[6] = '{"xor_zero", 4'h5, 8'hAA,  8'hAA,  8'h00,  1'b1};
        vecs[7] = '{"xor",      4'h5, 8'hA5,  8'h0F,  8'hAA,  1'b0};
        vecs[8] = '{"mov",      4'h6, 8'h42,  8'h99,  8'h42,  1'b0};
        vecs[9] = '{"sub_big",  4'h2, 8'd0,   8'd1,   8'd255, 1'b0};

`ifdef SEQ_STEP_EN
        step = 1'b1;
`endif
        clear_rom();

        // Reset state, sampled while reset is held.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mar", mar, 0);
        check("rst_rd_sel", rd_sel, 0);
        check("rst_wr_sel", wr_sel, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_out", out, 0);
        check("rst_abc", {a, b, c}, 0);
        check("rst_zero", zero, 0);
        check("rst_halted", halted, 0);

        // Write-back timing: LDI r1,5; LDI r2,3; ADD r3,r1,r2.
        clear_rom();
        rom[0] = 16'h7105;
        rom[1] = 16'h7203;
        rom[2] = 16'h1312;
        do_reset();
        wr_cycles = 0;
        last_wr   = 0;
        wsel_at   = '0;
        out_at    = '0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (wr_en) begin
                wr_cycles++;
                last_wr = cyc;
                wsel_at = wr_sel;
                out_at  = out;
            end
        end
        check("wb_count", wr_cycles, 3);
        check("wb_cycle", last_wr, 14);
        check("wb_sel", wsel_at, 3);
        check("wb_out", out_at, 8);
        check("wb_rf3", rf[3], 8);

        // Table of ALU programs: LDI r1,va; LDI r2,vb; OP r3,r1,r2; HALT.
        foreach (vecs[i]) begin
            clear_rom();
            rom[0] = {4'h7, 4'h1, vecs[i].va};
            rom[1] = {4'h7, 4'h2, vecs[i].vb};
            rom[2] = {vecs[i].op, 4'h3, 4'h1, 4'h2};
            rom[3] = 16'hF000;
            do_reset();
            wait_halt(vecs[i].name, 40);
            check({vecs[i].name, "_c"}, c, vecs[i].exp_c);
            check({vecs[i].name, "_rf"}, rf[3], vecs[i].exp_c);
            check({vecs[i].name, "_zero"}, zero, vecs[i].exp_z);
            check({vecs[i].name, "_mar"}, mar, 4);
        end

        // JZ taken: LDI r1,5; SUB r5,r1,r1; JZ 0.
        clear_rom();
        rom[0] = 16'h7105;
        rom[1] = 16'h2511;
        rom[2] = 16'h9000;
        do_reset();
        repeat (12) @(negedge clk);
        check("jz_decode_mar", mar, 3);
        check("jz_zero", zero, 1);
        @(negedge clk);
        check("jz_taken_mar", mar, 0);

        // JZ not taken, then JMP 7: LDI r1,5; SUB r5,r1,r0; JZ 0; JMP 7.
        clear_rom();
        rom[0] = 16'h7105;
        rom[1] = 16'h2510;
        rom[2] = 16'h9000;
        rom[3] = 16'h8007;
        do_reset();
        repeat (13) @(negedge clk);
        check("jz_nt_zero", zero, 0);
        check("jz_nt_mar", mar, 3);
        check("jz_nt_rf5", rf[5], 5);
        repeat (2) @(negedge clk);
        check("jmp_mar", mar, 7);

        // PC wrap with all-NOP ROM: FETCH cycles are the odd ones.
        clear_rom();
        do_reset();
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            check($sformatf("wrap_mar_%0d", k), mar, k % 16);
            @(negedge clk);
        end

        // HALT at address 4: mar frozen at 5, then reset recovers.
        clear_rom();
        rom[4] = 16'hF000;
        do_reset();
        wait_halt("halt", 30);
        check("halt_mar", mar, 5);
        mar_stuck = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mar !== 4'd5 || !halted || wr_en) mar_stuck = 1'b0;
        end
        check("halt_frozen", mar_stuck, 1);
        reset = 1'b1;
        #1;
        check("halt_rst_mar", mar, 0);
        check("halt_rst_halted", halted, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset abort during the ADD write-back cycle.
        clear_rom();
        rom[0] = 16'h7105;
        rom[1] = 16'h7203;
        rom[2] = 16'h1312;
        do_reset();
        repeat (14) @(negedge clk);
        check("abort_pre_wr_en", wr_en, 1);
        reset = 1'b1;
        #1;
        check("abort_wr_en", wr_en, 0);
        check("abort_outs", {mar, rd_sel, wr_sel, out, a, b, c}, 0);
        check("abort_flags", {zero, halted}, 0);
        @(posedge clk);
        #1;
        check("abort_rf3", rf[3], 0);

`ifdef SEQ_STEP_EN
        // Step held low: nothing is fetched or written.
        step = 1'b0;
        #1 reset = 1'b0;
        wr_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wr_en) wr_cycles++;
        end
        check("step_mar", mar, 0);
        check("step_writes", wr_cycles, 0);
        step = 1'b1;
`else
        #1 reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
